// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: collects big-endian message words into 512-bit blocks,
// appends the 0x80 marker and 64-bit bit length, streams blocks to the core, latches the digest.
module sha1_msg_padder #(
  parameter int WORDSIZE = 32,
  parameter int WORDNUM  = 16,
  parameter int LENSIZE  = 64
) (
  input  logic                iClk,
  input  logic                reset,
  input  logic [WORDSIZE-1:0] iDat,
  input  logic                iValid,
  input  logic                iLast,
  input  logic [2:0]          iBytes,
  output logic                oReady,
  output logic [WORDSIZE-1:0] oCoreDat,
  output logic                oCoreValid,
  output logic                oCoreInitial,
  input  logic                iCoreReady,
  input  logic [159:0]        iCoreDigest,
  output logic [159:0]        oDigest,
  output logic                oDone
);

  localparam int IDXW = $clog2(WORDNUM);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_SEND, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [WORDSIZE-1:0] blk_q [WORDNUM];
  logic [IDXW-1:0]     idx_q, lidx_q, cnt_q;
  logic [LENSIZE-1:0]  bitlen_q;
  logic [2:0]          lbytes_q;
  logic                first_q, pend_q, owe_q, final_q, done_q;
  logic [159:0]        digest_q;

  logic                xfer;
  logic [2:0]          bytes_w;
  logic [IDXW:0]       pad_pos;
  logic                wait_go;

  // Keep the valid leading bytes, place the 0x80 marker right after them, zero the rest.
  // A full last word (nb==4) pushes the marker into a fresh word of its own.
  function automatic logic [WORDSIZE-1:0] pad_word(input logic [WORDSIZE-1:0] w,
                                                   input logic [2:0] nb);
    case (nb)
      3'd1:    pad_word = {w[31:24], 24'h80_0000};
      3'd2:    pad_word = {w[31:16], 16'h8000};
      3'd3:    pad_word = {w[31:8], 8'h80};
      default: pad_word = 32'h8000_0000;
    endcase
  endfunction

  assign xfer    = iValid && (state_q == S_FILL);
  assign bytes_w = (iBytes > 3'd4) ? 3'd4 : iBytes;
  assign pad_pos = (lbytes_q == 3'd4) ? ({1'b0, lidx_q} + (IDXW+1)'(1)) : {1'b0, lidx_q};
  // The core only drops ready a cycle after word 0, so its first two WAIT cycles are stale.
  assign wait_go = (state_q == S_WAIT) && (cnt_q >= IDXW'(2)) && iCoreReady;

  always_comb begin
    state_d      = state_q;
    oReady       = 1'b0;
    oCoreValid   = 1'b0;
    oCoreInitial = 1'b0;
    oCoreDat     = '0;
    case (state_q)
      S_FILL: begin
        oReady = 1'b1;
        if (xfer) begin
          if (iLast) state_d = S_PAD;
          else if (idx_q == IDXW'(WORDNUM-1)) state_d = S_SEND;
        end
      end
      S_PAD: state_d = S_SEND;
      S_SEND: begin
        oCoreValid   = 1'b1;
        oCoreDat     = blk_q[cnt_q];
        oCoreInitial = first_q && (cnt_q == '0);
        if (cnt_q == IDXW'(WORDNUM-1)) state_d = S_WAIT;
      end
      S_WAIT: if (wait_go) state_d = (!final_q && pend_q) ? S_SEND : S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (reset) begin
      state_q  <= S_FILL;
      idx_q    <= '0;
      cnt_q    <= '0;
      bitlen_q <= '0;
      first_q  <= 1'b1;
      pend_q   <= 1'b0;
      owe_q    <= 1'b0;
      final_q  <= 1'b0;
      done_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_FILL: if (xfer) begin
          idx_q    <= idx_q + IDXW'(1);
          bitlen_q <= bitlen_q + (iLast ? LENSIZE'({bytes_w, 3'b000}) : LENSIZE'(WORDSIZE));
        end
        S_PAD: begin
          cnt_q <= '0;
          if (pad_pos <= (IDXW+1)'(WORDNUM-3)) final_q <= 1'b1;
          else begin
            pend_q <= 1'b1;
            owe_q  <= (pad_pos == (IDXW+1)'(WORDNUM));
          end
        end
        S_SEND: begin
          cnt_q <= cnt_q + IDXW'(1);
          if (cnt_q == '0) first_q <= 1'b0;
        end
        S_WAIT: begin
          if (cnt_q < IDXW'(2)) cnt_q <= cnt_q + IDXW'(1);
          else if (iCoreReady) begin
            idx_q <= '0;
            cnt_q <= '0;
            if (final_q) begin
              digest_q <= iCoreDigest;
              done_q   <= 1'b1;
              first_q  <= 1'b1;
              bitlen_q <= '0;
              final_q  <= 1'b0;
            end else if (pend_q) begin
              pend_q  <= 1'b0;
              owe_q   <= 1'b0;
              final_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Block buffer is pure data and carries no reset.
  always_ff @(posedge iClk) begin
    case (state_q)
      S_FILL: if (xfer) begin
        blk_q[idx_q] <= iDat;
        lidx_q       <= idx_q;
        lbytes_q     <= bytes_w;
      end
      S_PAD: begin
        for (int i = 0; i < WORDNUM; i++) begin
          if ((IDXW+1)'(i) == pad_pos) blk_q[i] <= pad_word(blk_q[i], lbytes_q);
          else if ((IDXW+1)'(i) > pad_pos) blk_q[i] <= '0;
        end
        if (pad_pos <= (IDXW+1)'(WORDNUM-3)) begin
          blk_q[WORDNUM-2] <= bitlen_q[LENSIZE-1:WORDSIZE];
          blk_q[WORDNUM-1] <= bitlen_q[WORDSIZE-1:0];
        end
      end
      S_WAIT: if (wait_go && !final_q && pend_q) begin
        for (int i = 0; i < WORDNUM-2; i++) blk_q[i] <= '0;
        if (owe_q) blk_q[0] <= 32'h8000_0000;
        blk_q[WORDNUM-2] <= bitlen_q[LENSIZE-1:WORDSIZE];
        blk_q[WORDNUM-1] <= bitlen_q[WORDSIZE-1:0];
      end
      default: ;
    endcase
  end

  assign oDigest = digest_q;
  assign oDone   = done_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Scoreboard bench for sha1_msg_padder: byte-level padding reference, behavioural SHA-1 core,
// randomized word gaps and core stall times.
module tb_sha1_msg_padder;

  logic         iClk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  iDat = '0;
  logic         iValid = 1'b0;
  logic         iLast = 1'b0;
  logic [2:0]   iBytes = '0;
  logic         oReady;
  logic [31:0]  oCoreDat;
  logic         oCoreValid;
  logic         oCoreInitial;
  logic         iCoreReady = 1'b1;
  logic [159:0] iCoreDigest = '0;
  logic [159:0] oDigest;
  logic         oDone;

  sha1_msg_padder dut (
    .iClk(iClk), .reset(reset), .iDat(iDat), .iValid(iValid), .iLast(iLast), .iBytes(iBytes),
    .oReady(oReady), .oCoreDat(oCoreDat), .oCoreValid(oCoreValid), .oCoreInitial(oCoreInitial),
    .iCoreReady(iCoreReady), .iCoreDigest(iCoreDigest), .oDigest(oDigest), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] D_56    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0]  exp_words [$];
  logic [159:0] exp_dig [$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                    k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d);  k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                    k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Reference: pad at byte level, then split into words/blocks.
  task automatic push_expected(input logic [7:0] m[$], input bit use_known, input logic [159:0] known);
    logic [7:0]   p [$];
    logic [63:0]  bl;
    logic [511:0] blk;
    logic [159:0] h;
    logic [31:0]  wd;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = IV;
    blk = '0;
    for (int w = 0; w < p.size() / 4; w++) begin
      wd = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
      exp_words.push_back({(w == 0), wd});
      blk[511-32*(w%16) -: 32] = wd;
      if (w % 16 == 15) h = sha1_compress(h, blk);
    end
    exp_dig.push_back(use_known ? known : h);
  endtask

  task automatic send_msg(input logic [7:0] m[$], input bit gaps);
    int n, nw, nb, to;
    logic [31:0] dat;
    bit last;
    n  = m.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      last = (w == nw - 1);
      nb   = last ? n - 4*w : 4;
      dat  = $urandom;
      for (int b = 0; b < 4; b++) if (b < nb) dat[31-8*b -: 8] = m[4*w+b];
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge iClk);
      to = 0;
      while (!oReady && to < 2000) begin @(negedge iClk); to++; end
      if (!oReady) begin
        n_tests++; n_fail++;
        $display("FAIL ready_timeout: oReady stayed %0d, required 1", oReady);
        return;
      end
      iDat   = dat;
      iValid = 1'b1;
      iLast  = last;
      iBytes = (nb == 4) ? 3'($urandom_range(4, 7)) : 3'(nb);
      @(negedge iClk);
      iValid = 1'b0;
      iLast  = 1'b0;
      if (last) begin
        chk("pad_cycle_no_word", 160'(oCoreValid), 160'd0);
        chk("pad_cycle_ready", 160'(oReady), 160'd0);
        @(negedge iClk);
        chk("last_to_send_t2", 160'(oCoreValid), 160'd1);
      end else if (w % 16 == 15) begin
        chk("full_to_send_t1", 160'(oCoreValid), 160'd1);
      end
    end
  endtask

  task automatic drain();
    int to = 0;
    while ((exp_dig.size() != 0 || exp_words.size() != 0) && to < 5000) begin
      @(negedge iClk); to++;
    end
    chk("drain_words", 160'(exp_words.size()), 160'd0);
    chk("drain_digests", 160'(exp_dig.size()), 160'd0);
  endtask

  // Behavioural SHA-1 core with random busy time.
  int           core_cnt = 0;
  int           core_dly = 0;
  bit           core_busy = 1'b0;
  logic [511:0] core_blk = '0;
  logic [159:0] core_h = IV;
  initial begin
    forever begin
      @(negedge iClk);
      if (reset) begin
        core_cnt = 0; core_busy = 1'b0; iCoreReady = 1'b1; core_h = IV;
      end else if (oCoreValid) begin
        if (core_cnt == 0) begin
          iCoreReady = 1'b0;
          if (oCoreInitial) core_h = IV;
        end
        core_blk[511-32*core_cnt -: 32] = oCoreDat;
        core_cnt++;
        if (core_cnt == 16) begin
          core_h    = sha1_compress(core_h, core_blk);
          core_cnt  = 0;
          core_busy = 1'b1;
          core_dly  = $urandom_range(0, 6);
        end
      end else if (core_busy) begin
        if (core_dly == 0) begin
          iCoreDigest = core_h; iCoreReady = 1'b1; core_busy = 1'b0;
        end else core_dly--;
      end
    end
  end

  // Monitor: pop expectations whenever the DUT presents a core word or a digest.
  bit prev_done = 1'b0;
  initial begin
    forever begin
      @(negedge iClk);
      if (prev_done) chk("done_one_cycle", 160'(oDone), 160'd0);
      prev_done = oDone;
      if (oCoreValid) begin
        chk("ready_low_in_send", 160'(oReady), 160'd0);
        if (exp_words.size() == 0) chk("unexpected_core_word", 160'({oCoreInitial, oCoreDat}), 160'h0);
        else chk("core_word", 160'({oCoreInitial, oCoreDat}), 160'(exp_words.pop_front()));
      end
      if (oDone) begin
        if (exp_dig.size() == 0) chk("unexpected_done", oDigest, 160'h0);
        else chk("digest", oDigest, exp_dig.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] m [$];
    string s;
    int lens [11] = '{55, 60, 61, 63, 65, 100, 119, 128, 3, 1, 2};

    repeat (3) @(negedge iClk);
    chk("rst_ready", 160'(oReady), 160'd1);
    chk("rst_core_valid", 160'(oCoreValid), 160'd0);
    chk("rst_core_initial", 160'(oCoreInitial), 160'd0);
    chk("rst_core_dat", 160'(oCoreDat), 160'd0);
    chk("rst_done", 160'(oDone), 160'd0);
    chk("rst_digest", oDigest, 160'd0);
    reset = 1'b0;

    m = {8'h61, 8'h62, 8'h63};
    push_expected(m, 1'b1, D_ABC);
    send_msg(m, 1'b0);

    m = {};
    push_expected(m, 1'b1, D_EMPTY);
    send_msg(m, 1'b1);

    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    m = {};
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    push_expected(m, 1'b1, D_56);
    send_msg(m, 1'b1);

    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    push_expected(m, 1'b0, '0);
    send_msg(m, 1'b0);

    foreach (lens[j]) begin
      m = {};
      for (int i = 0; i < lens[j]; i++) m.push_back(8'($urandom));
      push_expected(m, 1'b0, '0);
      send_msg(m, 1'b1);
    end
    drain();

    // Abort "abc" while word 7 is on the core bus.
    m = {8'h61, 8'h62, 8'h63};
    push_expected(m, 1'b1, D_ABC);
    send_msg(m, 1'b0);
    repeat (7) @(negedge iClk);
    reset = 1'b1;
    @(negedge iClk);
    chk("midrst_core_valid", 160'(oCoreValid), 160'd0);
    chk("midrst_ready", 160'(oReady), 160'd1);
    chk("midrst_done", 160'(oDone), 160'd0);
    chk("midrst_digest", oDigest, 160'd0);
    exp_words.delete();
    exp_dig.delete();
    @(negedge iClk);
    reset = 1'b0;

    push_expected(m, 1'b1, D_ABC);
    send_msg(m, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
